serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fullAdder.sv | 13 +
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and default operand width for the serial_adder block.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fullAdder.sv
// One-bit full adder cell used as the bit-slice datapath of serial_adder.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c_in;
  assign carry = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder wrapping one fullAdder cell, LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_sum;
  logic             bit_carry;
  logic             accept;
  logic             last_bit;

  // A new request is taken from IDLE or DONE, which gives back-to-back operation.
  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (state == ST_SHIFT) && (cnt == LAST_BIT);

  fullAdder u_bit (
    .a     (shift_a[0]),
    .b     (shift_b[0]),
    .c_in  (carry),
    .sum   (bit_sum),
    .carry (bit_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_SHIFT);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else if (accept) begin
      shift_a <= op_a;
      shift_b <= op_b;
      carry   <= c_in;
      cnt     <= '0;
    end else if (state == ST_SHIFT) begin
      shift_a <= {1'b0, shift_a[WIDTH-1:1]};
      shift_b <= {1'b0, shift_b[WIDTH-1:1]};
      carry   <= bit_carry;
      cnt     <= cnt + CNT_W'(1);
      sum     <= {bit_sum, sum[WIDTH-1:1]};
      if (last_bit) begin
        c_out <= bit_carry;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the MSB slice the stored carry is the carry into the sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (last_bit) begin
      overflow <= carry ^ bit_carry;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: random and directed adds against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           due;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         overflow;
`endif

  int   checks;
  int   failures;
  int   cyc;
  exp_t sb[$];
  exp_t mon_e;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t       m;
    logic [W:0] t;
    t    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    m.s  = t[W-1:0];
    m.co = t[W];
    m.ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    m.due = 0;
    return m;
  endfunction

  // Present a request before an edge; once it is taken, queue the expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t e;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    c_in  = ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    e     = model(a, b, ci);
    e.due = cyc + W;
    sb.push_back(e);
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_idle();
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  int'(busy),  0);
    chk({tag, "_done"},  int'(done),  0);
    chk({tag, "_sum"},   int'(sum),   0);
    chk({tag, "_c_out"}, int'(c_out), 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_overflow"}, int'(overflow), 0);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_latency", cyc, mon_e.due);
        chk("sum", int'(sum), int'(mon_e.s));
        chk("c_out", int'(c_out), int'(mon_e.co));
`ifdef SERIAL_ADDER_OVF_EN
        chk("overflow", int'(overflow), int'(mon_e.ov));
`endif
        chk("busy_at_done", int'(busy), 0);
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      chk("missing_done", 0, 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    c_in     = 1'b0;
    #3;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic add with the busy window observed cycle by cycle.
    issue(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int i = 1; i < W; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (i < W - 1) @(negedge clk);
    end
    chk("busy_window", bad, 0);
    wait_idle();

    issue(8'hFF, 8'h01, 1'b0); wait_idle();
    issue(8'h7F, 8'h01, 1'b0); wait_idle();
    issue(8'h00, 8'h00, 1'b1); wait_idle();
    issue(8'hFF, 8'hFF, 1'b1); wait_idle();

    // A second start while shifting must be ignored.
    issue(8'h12, 8'h34, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    op_a = 8'hAA; op_b = 8'h55; c_in = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // start held high: the second request is taken in the DONE cycle.
    issue(8'h01, 8'h02, 1'b0);
    repeat (W) @(negedge clk);
    issue(8'h10, 8'h20, 1'b0);
    wait_idle();

    // Reset in the middle of an add.
    issue(8'h33, 8'h44, 1'b1);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    issue(8'hC8, 8'h64, 1'b0); wait_idle();

    // Random operands with random gaps, including back-to-back requests.
    for (int n = 0; n < 40; n++) begin
      int gap;
      issue(W'($urandom), W'($urandom), 1'($urandom));
      @(negedge clk); start = 1'b0;
      repeat (W - 1) @(negedge clk);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
    wait_idle();

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
